mmio_timer: RTL and testbench
=============================

MMIO_TIMER -- requirements
Module: mmio_timer

Interface
REQ-001 Parameter BASE, default 32'h0000_0400, byte address of the 16-byte register window.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 we  input  1  write strobe from the processor (MemWrite).
REQ-005 a  input  32  byte address from the processor (Adr).
REQ-006 wd  input  32  write data from the processor (WriteData).
REQ-007 rd  output  32  read data for the processor's read-data mux.
REQ-008 sel  output  1  high when a falls inside the window; steers the read mux away from mem.
REQ-009 irq  output  1  level interrupt request.

Function
REQ-010 sel SHALL be 1 when a[31:4] == BASE[31:4], else 0; a[1:0] ignored; register index = a[3:2].
REQ-011 Registers: 0 CTRL, 1 LOAD, 2 COUNT, 3 STATUS.
- CTRL bit0 EN, bit1 AUTO (auto-reload), bit2 IE (irq enable), bits[15:8] PRE (prescale).
- CTRL other bits read 0.
REQ-012 rd SHALL be combinational from a and register state.
- Unused bits read 0.
- rd = 0 when sel = 0.
REQ-013 Writes SHALL occur on the rising clk edge when we & sel; we with sel = 0 SHALL change nothing.
REQ-014 COUNT SHALL be read-only; writes to index 2 ignored.
REQ-015 LOAD write SHALL set LOAD <= wd, COUNT <= wd and prescaler PC <= 0 in the same edge.
REQ-016 STATUS bit0 EXP SHALL be write-1-to-clear; writing 0 leaves it unchanged.
REQ-017 Prescaler PC (8 bit) SHALL run only while EN = 1.
- PC == PRE: tick asserted this cycle, PC <= 0.
- Otherwise PC <= PC + 1.
- Tick period = PRE + 1 cycles; PRE = 0 gives a tick every cycle.
REQ-018 On tick with COUNT != 0: COUNT <= COUNT - 1.
REQ-019 On tick with COUNT == 0: EXP <= 1.
- AUTO = 1: COUNT <= LOAD.
- AUTO = 0: EN <= 0, COUNT held at 0.
REQ-020 Timer states: IDLE (EN = 0), RUN (EN = 1); RUN -> IDLE on one-shot expiry or CTRL write with EN = 0; IDLE -> RUN only by CTRL write with EN = 1.
REQ-021 CTRL write changing EN 0 -> 1 SHALL clear PC to 0.
REQ-022 Simultaneous LOAD write and tick: the LOAD write wins; no decrement, no expiry that edge.
REQ-023 Simultaneous EXP W1C and expiry event: set wins, EXP = 1.
REQ-024 Simultaneous CTRL write and one-shot auto-clear of EN: the CTRL write wins.
REQ-025 COUNT SHALL be 32-bit unsigned, never decrement below 0, no wrap.
REQ-026 irq SHALL equal EXP & IE (registered state, no combinational path from inputs).

Reset
REQ-027 reset = 1 SHALL asynchronously force CTRL, LOAD, COUNT, PC, EXP to 0, hence irq = 0.
- rd = 0 for all in-window reads while reset is held.
REQ-028 Reset asserted mid-count SHALL abort the count; after release the timer stays IDLE until EN is written.

Verification
REQ-029 Reset: assert mid-run with COUNT = 5 -> all registers read 0, irq = 0 immediately, before any clk edge.
REQ-030 One-shot: LOAD = 3, CTRL = 0x0000_0005 (EN, IE, PRE = 0).
- EXP = 1 and irq = 1 exactly 4 cycles after the EN write edge.
- CTRL reads 0x4 afterwards; COUNT stays 0.
REQ-031 Auto-reload with prescale: LOAD = 2, CTRL = 0x0000_0303 (EN, AUTO, PRE = 3).
- COUNT steps 2, 1, 0, then back to 2 every 4 cycles.
- EXP sets every 12 cycles.
REQ-032 W1C and collision:
- Write STATUS = 1 with EXP = 1 -> EXP = 0, irq drops next cycle.
- Write STATUS = 1 on the same edge as an expiry -> EXP stays 1.
REQ-033 Decode:
- Write 0xDEAD_BEEF to a = BASE + 0x10 -> no register changes, sel = 0, rd = 0.
- Write to a = BASE + 0x8 -> COUNT unchanged.
- a = BASE + 0x7 reads LOAD.
REQ-034 LOAD vs tick: LOAD write of 9 on a tick edge with COUNT = 0 -> COUNT = 9, EXP unchanged, PC = 0.

Source files
------------

// File: rtl/mmio_timer_if.sv
// Processor-side bus of the memory-mapped timer: write strobe, address,
// write data, plus read data, window select and interrupt back to the core.
interface mmio_timer_if;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        sel;
  logic        irq;

  modport master (
    output we, a, wd,
    input  rd, sel, irq
  );

  modport slave (
    input  we, a, wd,
    output rd, sel, irq
  );
endinterface

// File: rtl/mmio_timer.sv
// Memory-mapped down-counting timer with 8-bit prescaler, auto-reload,
// write-1-to-clear expiry flag and level interrupt (CTRL/LOAD/COUNT/STATUS).
module mmio_timer #(
  parameter logic [31:0] BASE = 32'h0000_0400
) (
  input  logic         clk,
  input  logic         reset,
  mmio_timer_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nx;

  logic        auto_rl;
  logic        ie;
  logic [7:0]  pre;
  logic [7:0]  pc;
  logic [31:0] load;
  logic [31:0] count;
  logic        exp;

  logic [1:0]  idx;
  logic        wr;
  logic        wr_ctrl;
  logic        wr_load;
  logic        wr_stat;
  logic        en_rise;
  logic        tick;
  logic        expire;

  // Address decode and write qualification
  assign bus.sel = (bus.a[31:4] == BASE[31:4]);
  assign idx     = bus.a[3:2];
  assign wr      = bus.we & bus.sel;
  assign wr_ctrl = wr & (idx == 2'd0);
  assign wr_load = wr & (idx == 2'd1);
  assign wr_stat = wr & (idx == 2'd3);

  assign en_rise = wr_ctrl & bus.wd[0] & (state == IDLE);
  assign tick    = (state == RUN) & (pc == pre);
  // A LOAD write on a tick edge suppresses both decrement and expiry.
  assign expire  = tick & (count == '0) & ~wr_load;

  assign bus.irq = exp & ie;

  // Timer state: RUN is exactly CTRL.EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (wr_ctrl && bus.wd[0]) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        // A CTRL write on the same edge as one-shot expiry takes priority.
        if (wr_ctrl) begin
          state_nx = bus.wd[0] ? RUN : IDLE;
        end else if (expire && !auto_rl) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // CTRL fields other than EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      auto_rl <= 1'b0;
      ie      <= 1'b0;
      pre     <= '0;
    end else if (wr_ctrl) begin
      auto_rl <= bus.wd[1];
      ie      <= bus.wd[2];
      pre     <= bus.wd[15:8];
    end
  end

  // Prescaler: restarts on LOAD write or enable, free-runs only while RUN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= '0;
    end else if (wr_load || en_rise) begin
      pc <= '0;
    end else if (state == RUN) begin
      pc <= tick ? '0 : pc + 8'd1;
    end
  end

  // LOAD and COUNT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load  <= '0;
      count <= '0;
    end else if (wr_load) begin
      load  <= bus.wd;
      count <= bus.wd;
    end else if (tick) begin
      if (count != '0) begin
        count <= count - 32'd1;
      end else if (auto_rl) begin
        count <= load;
      end
    end
  end

  // Expiry flag: set beats write-1-to-clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp <= 1'b0;
    end else if (expire) begin
      exp <= 1'b1;
    end else if (wr_stat && bus.wd[0]) begin
      exp <= 1'b0;
    end
  end

  // Read mux
  always_comb begin
    bus.rd = '0;
    if (bus.sel) begin
      unique case (idx)
        2'd0: bus.rd = {16'h0000, pre, 5'b00000, ie, auto_rl, (state == RUN)};
        2'd1: bus.rd = load;
        2'd2: bus.rd = count;
        2'd3: bus.rd = {31'd0, exp};
        default: bus.rd = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: vector table, directed corner-case
// sequences and randomized traffic against a behavioural model.
module tb_mmio_timer;

  localparam logic [31:0] BASE = 32'h0000_0400;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mmio_timer_if bus ();

  mmio_timer #(.BASE(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Behavioural model state
  logic        m_en, m_auto, m_ie, m_exp;
  logic [7:0]  m_pre, m_pc;
  logic [31:0] m_load, m_count;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] addr);
    if (addr[31:4] != BASE[31:4]) return 32'h0;
    case (addr[3:2])
      2'd0:    return {16'h0000, m_pre, 5'b00000, m_ie, m_auto, m_en};
      2'd1:    return m_load;
      2'd2:    return m_count;
      default: return {31'd0, m_exp};
    endcase
  endfunction

  task automatic model_reset();
    m_en = 0; m_auto = 0; m_ie = 0; m_exp = 0;
    m_pre = 0; m_pc = 0; m_load = 0; m_count = 0;
  endtask

  // One clock edge of the timer, derived from the register-level rules.
  task automatic model_step(input logic we, input logic [31:0] a, input logic [31:0] wd);
    logic        hit, tick, ld, fired;
    logic [1:0]  r;
    logic        n_en, n_exp;
    logic [7:0]  n_pc;
    logic [31:0] n_count;
    hit  = we && (a[31:4] == BASE[31:4]);
    r    = a[3:2];
    ld   = hit && (r == 2'd1);
    tick = m_en && (m_pc == m_pre);
    fired = tick && !ld && (m_count == 0);

    n_pc    = m_en ? (tick ? 8'd0 : m_pc + 8'd1) : m_pc;
    n_count = m_count;
    n_en    = m_en;
    if (ld) n_count = wd;
    else if (tick && m_count > 0) n_count = m_count - 1;
    else if (fired && m_auto) n_count = m_load;
    if (fired && !m_auto) n_en = 0;

    n_exp = m_exp;
    if (hit && r == 2'd3 && wd[0]) n_exp = 0;
    if (fired) n_exp = 1;

    if (hit && r == 2'd0) begin
      if (!m_en && wd[0]) n_pc = 0;
      n_en   = wd[0];
      m_auto = wd[1];
      m_ie   = wd[2];
      m_pre  = wd[15:8];
    end
    if (ld) begin
      n_pc   = 0;
      m_load = wd;
    end
    m_pc = n_pc; m_count = n_count; m_en = n_en; m_exp = n_exp;
  endtask

  // Drive one bus cycle, compare outputs before the edge, then advance the model.
  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] wd);
    bus.we = we; bus.a = a; bus.wd = wd;
    @(negedge clk);
    chk("rd",  bus.rd, model_rd(a));
    chk("sel", {31'd0, bus.sel}, {31'd0, (a[31:4] == BASE[31:4])});
    chk("irq", {31'd0, bus.irq}, {31'd0, m_exp & m_ie});
    @(posedge clk);
    model_step(we, a, wd);
    #1;
  endtask

  task automatic peek(input string name, input int unsigned r, input logic [31:0] want);
    bus.we = 1'b0;
    bus.a  = BASE + 32'(r * 4);
    #1;
    chk(name, bus.rd, want);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        sel;
    logic        irq;
  } vec_t;

  vec_t tbl[15];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rw;
    bus.we = 0; bus.a = 0; bus.wd = 0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    peek("rst_ctrl", 0, 32'h0);
    peek("rst_load", 1, 32'h0);
    peek("rst_count", 2, 32'h0);
    chk("rst_irq", {31'd0, bus.irq}, 32'h0);

    // Decode / read-back vectors; rd is the value before the row's edge
    tbl[0]  = '{1'b0, BASE + 32'h0,  32'h0,         32'h0,         1'b1, 1'b0};
    tbl[1]  = '{1'b1, BASE + 32'h4,  32'h1234_5678, 32'h0,         1'b1, 1'b0};
    tbl[2]  = '{1'b0, BASE + 32'h7,  32'h0,         32'h1234_5678, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, BASE + 32'h8,  32'h0,         32'h1234_5678, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, BASE + 32'h8,  32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, BASE + 32'h8,  32'h0,         32'h1234_5678, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 32'h0,         1'b0, 1'b0};
    tbl[7]  = '{1'b0, BASE + 32'h4,  32'h0,         32'h1234_5678, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, BASE + 32'h0,  32'h0,         32'h0,         1'b1, 1'b0};
    tbl[9]  = '{1'b1, BASE + 32'h0,  32'hFFFF_FFF6, 32'h0,         1'b1, 1'b0};
    tbl[10] = '{1'b0, BASE + 32'h0,  32'h0,         32'h0000_FF06, 1'b1, 1'b0};
    tbl[11] = '{1'b0, BASE - 32'h4,  32'h0,         32'h0,         1'b0, 1'b0};
    tbl[12] = '{1'b0, BASE + 32'hC,  32'h0,         32'h0,         1'b1, 1'b0};
    tbl[13] = '{1'b1, BASE + 32'h0,  32'h0,         32'h0000_FF06, 1'b1, 1'b0};
    tbl[14] = '{1'b0, BASE + 32'h3,  32'h0,         32'h0,         1'b1, 1'b0};
    for (int i = 0; i < 15; i++) begin
      bus.we = tbl[i].we; bus.a = tbl[i].a; bus.wd = tbl[i].wd;
      @(negedge clk);
      chk($sformatf("tbl%0d_rd", i), bus.rd, tbl[i].rd);
      chk($sformatf("tbl%0d_sel", i), {31'd0, bus.sel}, {31'd0, tbl[i].sel});
      chk($sformatf("tbl%0d_irq", i), {31'd0, bus.irq}, {31'd0, tbl[i].irq});
      @(posedge clk);
      model_step(tbl[i].we, tbl[i].a, tbl[i].wd);
      #1;
    end

    // Mid-run asynchronous reset with COUNT = 5 and irq high
    step(1, BASE + 32'h4, 32'h0);
    step(1, BASE + 32'h0, 32'h7);
    step(0, BASE + 32'h8, 32'h0);
    step(1, BASE + 32'h4, 32'h8);
    repeat (3) step(0, BASE + 32'h8, 32'h0);
    peek("pre_rst_count", 2, 32'h5);
    chk("pre_rst_irq", {31'd0, bus.irq}, 32'h1);
    reset = 1'b1;
    #1;
    chk("async_rst_irq", {31'd0, bus.irq}, 32'h0);
    peek("async_rst_ctrl", 0, 32'h0);
    peek("async_rst_load", 1, 32'h0);
    peek("async_rst_count", 2, 32'h0);
    peek("async_rst_status", 3, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    repeat (3) step(0, BASE + 32'h8, 32'h0);
    peek("post_rst_count", 2, 32'h0);
    peek("post_rst_ctrl", 0, 32'h0);

    // One-shot: expiry exactly 4 edges after the enabling write
    step(1, BASE + 32'h4, 32'h3);
    step(1, BASE + 32'h0, 32'h5);
    for (int i = 1; i <= 4; i++) begin
      step(0, BASE + 32'hC, 32'h0);
      chk($sformatf("oneshot_exp_e%0d", i), bus.rd, (i == 4) ? 32'h1 : 32'h0);
      chk($sformatf("oneshot_irq_e%0d", i), {31'd0, bus.irq}, (i == 4) ? 32'h1 : 32'h0);
    end
    peek("oneshot_ctrl", 0, 32'h4);
    peek("oneshot_count", 2, 32'h0);
    repeat (3) step(0, BASE + 32'h8, 32'h0);
    peek("oneshot_count_hold", 2, 32'h0);

    // W1C clears EXP and drops irq
    step(1, BASE + 32'hC, 32'h1);
    chk("w1c_irq", {31'd0, bus.irq}, 32'h0);
    peek("w1c_status", 3, 32'h0);

    // Auto-reload with PRE = 3: COUNT 2,1,0,2 every 4 edges, EXP every 12
    step(1, BASE + 32'h4, 32'h2);
    step(1, BASE + 32'h0, 32'h303);
    for (int i = 1; i <= 36; i++) begin
      if (i == 13 || i == 36) step(1, BASE + 32'hC, 32'h1);
      else step(0, BASE + 32'h8, 32'h0);
      peek($sformatf("auto_count_e%0d", i), 2, 32'(2 - ((i / 4) % 3)));
      peek($sformatf("auto_exp_e%0d", i), 3, (i == 12 || i >= 24) ? 32'h1 : 32'h0);
    end
    step(1, BASE + 32'h0, 32'h0);
    step(1, BASE + 32'hC, 32'h1);

    // CTRL write on the one-shot expiry edge keeps EN
    step(1, BASE + 32'h4, 32'h0);
    step(1, BASE + 32'h0, 32'h1);
    step(1, BASE + 32'h0, 32'h5);
    peek("ctrl_vs_expiry_ctrl", 0, 32'h5);
    peek("ctrl_vs_expiry_status", 3, 32'h1);
    step(1, BASE + 32'h0, 32'h0);
    step(1, BASE + 32'hC, 32'h1);

    // LOAD write on a tick edge with COUNT = 0
    step(1, BASE + 32'h4, 32'h1);
    step(1, BASE + 32'h0, 32'h201);
    repeat (5) step(0, BASE + 32'h8, 32'h0);
    step(1, BASE + 32'h4, 32'h9);
    peek("ld_tick_count", 2, 32'h9);
    peek("ld_tick_status", 3, 32'h0);
    peek("ld_tick_ctrl", 0, 32'h201);
    repeat (2) step(0, BASE + 32'h8, 32'h0);
    peek("ld_tick_pc_hold", 2, 32'h9);
    step(0, BASE + 32'h8, 32'h0);
    peek("ld_tick_pc_restart", 2, 32'h8);
    step(1, BASE + 32'h0, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0) ra = $urandom;
      else ra = BASE + 32'($urandom_range(19));
      case (ra[3:2])
        2'd0:    rw = {16'($urandom), 8'($urandom_range(3)), 8'($urandom)};
        2'd1:    rw = 32'($urandom_range(11));
        default: rw = $urandom;
      endcase
      step(1'($urandom_range(1)), ra, rw);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
